// File: rtl/mem_arbiter.sv
// Two-CPU memory arbiter. Data requests take priority over instruction requests,
// and each class uses round-robin between CPUs. Data grants may run a two-word block.
module mem_arbiter #(
  parameter int unsigned CPUS = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [CPUS-1:0]   iREN,
  input  logic [31:0]       iaddr    [CPUS],
  input  logic [CPUS-1:0]   dREN,
  input  logic [CPUS-1:0]   dWEN,
  input  logic [31:0]       daddr    [CPUS],
  input  logic [31:0]       dstore   [CPUS],
  output logic [CPUS-1:0]   iwait,
  output logic [CPUS-1:0]   dwait,
  output logic [31:0]       iload    [CPUS],
  output logic [31:0]       dload    [CPUS],
  output logic              ramREN,
  output logic              ramWEN,
  output logic [31:0]       ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic [1:0]        ramstate
);

  localparam logic [1:0] RamAccess = 2'd2;

  typedef enum logic {StIdle, StServe} state_e;

  state_e          state_q, state_d;
  logic            gnt_data_q, gnt_data_d;  // 1: data port, 0: instruction port
  logic            gnt_cpu_q, gnt_cpu_d;
  logic            beat_q, beat_d;
  logic            d_rr_q, d_rr_d;
  logic            i_rr_q, i_rr_d;
  logic [CPUS-1:0] d_req;
  logic            active;

  assign d_req = dREN | dWEN;

  always_comb begin
    for (int i = 0; i < CPUS; i++) begin
      iload[i] = ramload;
      dload[i] = ramload;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_data_d = gnt_data_q;
    gnt_cpu_d  = gnt_cpu_q;
    beat_d     = beat_q;
    d_rr_d     = d_rr_q;
    i_rr_d     = i_rr_q;
    active     = 1'b0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = '1;
    dwait      = '1;

    unique case (state_q)
      StIdle: begin
        if (|d_req) begin
          state_d    = StServe;
          gnt_data_d = 1'b1;
          gnt_cpu_d  = (&d_req) ? d_rr_q : ~d_req[0];
          beat_d     = 1'b0;
        end else if (|iREN) begin
          state_d    = StServe;
          gnt_data_d = 1'b0;
          gnt_cpu_d  = (&iREN) ? i_rr_q : ~iREN[0];
          beat_d     = 1'b0;
        end
      end

      StServe: begin
        active = gnt_data_q ? d_req[gnt_cpu_q] : iREN[gnt_cpu_q];
        if (active) begin
          if (gnt_data_q) begin
            ramaddr  = daddr[gnt_cpu_q];
            ramstore = dstore[gnt_cpu_q];
            ramWEN   = dWEN[gnt_cpu_q];
            ramREN   = dREN[gnt_cpu_q] & ~dWEN[gnt_cpu_q];
          end else begin
            ramaddr  = iaddr[gnt_cpu_q];
            ramREN   = 1'b1;
          end
          if (ramstate == RamAccess) begin
            if (gnt_data_q) dwait[gnt_cpu_q] = 1'b0;
            else            iwait[gnt_cpu_q] = 1'b0;
          end
        end

        // A dropped request or a final completion releases the grant and hands
        // round-robin priority to the other CPU of the same class.
        if (!active || (ramstate == RamAccess && (!gnt_data_q || beat_q))) begin
          state_d = StIdle;
          beat_d  = 1'b0;
          if (gnt_data_q) d_rr_d = ~gnt_cpu_q;
          else            i_rr_d = ~gnt_cpu_q;
        end else if (ramstate == RamAccess) begin
          beat_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= StIdle;
      gnt_data_q <= 1'b0;
      gnt_cpu_q  <= 1'b0;
      beat_q     <= 1'b0;
      d_rr_q     <= 1'b0;
      i_rr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      gnt_cpu_q  <= gnt_cpu_d;
      beat_q     <= beat_d;
      d_rr_q     <= d_rr_d;
      i_rr_q     <= i_rr_d;
    end
  end

endmodule
